// File: rtl/spi_frame_tx.sv
// spi_frame_tx: SPI mode-0 master that sends one frame per vsync rising edge.
// A frame is a header byte (frame counter) followed by up to MAX_BYTES payload bytes.
// Optional feature macro: SPI_TX_CRC_EN appends a CRC-8 (poly 0x07) byte before cs_n rises.
module spi_frame_tx #(
  parameter int unsigned CLK_DIV   = 112,
  parameter int unsigned MAX_BYTES = 64
) (
  input  logic       clk_27,
  input  logic       rst,
  input  logic       vsync,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       sclk,
  output logic       mosi,
  output logic       cs_n,
  output logic       busy,
  output logic [7:0] frame_cnt,
  output logic       overrun
);

  localparam int unsigned   PW      = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_HALF = PW'(CLK_DIV / 2);
  localparam logic [7:0]    MAX_CNT = 8'(MAX_BYTES);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_DATA = 3'd2,
`ifdef SPI_TX_CRC_EN
    S_CRC  = 3'd3,
`endif
    S_GAP  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          vsync_q;
  logic [PW-1:0] phase_q, phase_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic          overrun_q, overrun_d;
  logic          busy_q, busy_d;
  logic          cs_n_q, cs_n_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          tx_ready_q, tx_ready_d;
  logic          rise, phase_wrap, accept, in_crc;

`ifdef SPI_TX_CRC_EN
  logic [7:0] crc_q, crc_d;

  // One byte of CRC-8, poly 0x07, MSB first.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in, input logic [7:0] data);
    logic [7:0] c;
    c = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? (8'(c << 1) ^ 8'h07) : 8'(c << 1);
    end
    return c;
  endfunction

  assign in_crc = (state_q == S_CRC);
`else
  assign in_crc = 1'b0;
`endif

  assign rise       = vsync & ~vsync_q;
  assign phase_wrap = (phase_q == PH_LAST);
  assign accept     = tx_valid & tx_ready_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    frame_cnt_d = frame_cnt_q;
    busy_d      = busy_q;
    cs_n_d      = cs_n_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    tx_ready_d  = 1'b0;
    overrun_d   = overrun_q | (rise & (state_q != S_IDLE));
`ifdef SPI_TX_CRC_EN
    crc_d       = crc_q;
`endif
    if (state_q == S_IDLE) begin
      if (rise) begin
        state_d     = S_HDR;
        cs_n_d      = 1'b0;
        busy_d      = 1'b1;
        sclk_d      = 1'b0;
        shift_d     = frame_cnt_q;
        mosi_d      = frame_cnt_q[7];
        frame_cnt_d = frame_cnt_q + 8'd1;
        phase_d     = '0;
        bit_d       = 3'd0;
        cnt_d       = 8'd0;
`ifdef SPI_TX_CRC_EN
        crc_d       = crc8_byte(8'h00, frame_cnt_q);
`endif
      end
    end else if (state_q == S_GAP) begin
      cs_n_d = 1'b1;
      sclk_d = 1'b0;
      mosi_d = 1'b0;
      if (phase_wrap) begin
        phase_d = '0;
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end else begin
        phase_d = phase_q + PW'(1);
      end
    end else if (state_q == S_HDR || state_q == S_DATA || in_crc) begin
      if (!phase_wrap) begin
        phase_d = phase_q + PW'(1);
      end else begin
        phase_d = '0;
        if (bit_q != 3'd7) begin
          bit_d   = bit_q + 3'd1;
          shift_d = {shift_q[6:0], 1'b0};
          mosi_d  = shift_q[6];
        end else if (!in_crc && accept) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          shift_d = tx_data;
          mosi_d  = tx_data[7];
          cnt_d   = cnt_q + 8'd1;
`ifdef SPI_TX_CRC_EN
          crc_d   = crc8_byte(crc_q, tx_data);
`endif
`ifdef SPI_TX_CRC_EN
        end else if (!in_crc) begin
          state_d = S_CRC;
          bit_d   = 3'd0;
          shift_d = crc_q;
          mosi_d  = crc_q[7];
`endif
        end else begin
          state_d = S_GAP;
          bit_d   = 3'd0;
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
        end
      end
      sclk_d     = (state_d != S_GAP) && (phase_d >= PH_HALF);
      tx_ready_d = (state_d == S_HDR || state_d == S_DATA) && (phase_d == PH_LAST) &&
                   (bit_d == 3'd7) && (cnt_d < MAX_CNT);
    end else begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      cs_n_d  = 1'b1;
      sclk_d  = 1'b0;
      mosi_d  = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_27 or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      vsync_q     <= 1'b0;
      phase_q     <= '0;
      bit_q       <= 3'd0;
      shift_q     <= 8'd0;
      cnt_q       <= 8'd0;
      frame_cnt_q <= 8'd0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      tx_ready_q  <= 1'b0;
`ifdef SPI_TX_CRC_EN
      crc_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      vsync_q     <= vsync;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      frame_cnt_q <= frame_cnt_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
      cs_n_q      <= cs_n_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      tx_ready_q  <= tx_ready_d;
`ifdef SPI_TX_CRC_EN
      crc_q       <= crc_d;
`endif
    end
  end

  assign tx_ready  = tx_ready_q;
  assign sclk      = sclk_q;
  assign mosi      = mosi_q;
  assign cs_n      = cs_n_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_spi_frame_tx.sv
// tb_spi_frame_tx: scoreboard bench for spi_frame_tx (small CLK_DIV/MAX_BYTES for run time).
module tb_spi_frame_tx;

  localparam int unsigned CLK_DIV   = 8;
  localparam int unsigned MAX_BYTES = 4;

  logic       clk_27   = 1'b0;
  logic       rst      = 1'b1;
  logic       vsync    = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, sclk, mosi, cs_n, busy, overrun;
  logic [7:0] frame_cnt;

  spi_frame_tx #(.CLK_DIV(CLK_DIV), .MAX_BYTES(MAX_BYTES)) dut (
    .clk_27(clk_27), .rst(rst), .vsync(vsync), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .busy(busy),
    .frame_cnt(frame_cnt), .overrun(overrun)
  );

  always #5 clk_27 = ~clk_27;

  int         total = 0;
  int         bad   = 0;
  int         mcnt  = 0;
  logic       exp_ov = 1'b0;
  logic [7:0] src[$];
  logic [7:0] pl[$];
  logic [7:0] exp_bytes[$];
  int         exp_len[$];
  int         exp_rdy[$];

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // CRC-8 as the remainder of (message * x^8) divided by x^8+x^2+x+1.
  function automatic logic [7:0] crc_ref(input logic [7:0] msg[$]);
    logic [8:0] r;
    logic       b;
    int         nb;
    r  = 9'd0;
    nb = msg.size() * 8;
    for (int i = 0; i < nb + 8; i++) begin
      b = (i < nb) ? msg[i / 8][7 - (i % 8)] : 1'b0;
      r = {r[7:0], b};
      if (r[8]) r = r ^ 9'h107;
    end
    return r[7:0];
  endfunction

  // Expected frame: header = frames started so far, then the first MAX_BYTES offered bytes.
  task automatic push_frame(input logic [7:0] p[$]);
    logic [7:0] fr[$];
    int         k;
    k = (p.size() < MAX_BYTES) ? p.size() : MAX_BYTES;
    fr.push_back(8'(mcnt));
    for (int i = 0; i < k; i++) fr.push_back(p[i]);
`ifdef SPI_TX_CRC_EN
    fr.push_back(crc_ref(fr));
`endif
    exp_len.push_back(fr.size());
    foreach (fr[i]) exp_bytes.push_back(fr[i]);
    exp_rdy.push_back((p.size() < MAX_BYTES) ? p.size() + 1 : MAX_BYTES);
    src = p;
  endtask

  task automatic pulse_vsync();
    @(posedge clk_27); #1 vsync = 1'b1;
    repeat (2) @(posedge clk_27);
    #1 vsync = 1'b0;
  endtask

  task automatic wait_busy(input logic lvl);
    int n = 0;
    while (busy !== lvl && n < (MAX_BYTES + 4) * 8 * CLK_DIV) begin
      @(negedge clk_27);
      n++;
    end
    if (busy !== lvl) begin
      total++; bad++;
      $display("FAIL busy_timeout: busy=%0b required %0b", busy, lvl);
    end
  endtask

  task automatic wait_cs(input logic lvl);
    int n = 0;
    while (cs_n !== lvl && n < (MAX_BYTES + 4) * 8 * CLK_DIV) begin
      @(negedge clk_27);
      n++;
    end
    if (cs_n !== lvl) begin
      total++; bad++;
      $display("FAIL cs_timeout: cs_n=%0b required %0b", cs_n, lvl);
    end
  endtask

  task automatic run_frame(input logic [7:0] p[$]);
    push_frame(p);
    pulse_vsync();
    mcnt = (mcnt + 1) % 256;
    wait_busy(1'b1);
    wait_busy(1'b0);
    src.delete();
    check("frame_cnt", frame_cnt, mcnt);
    check("overrun", overrun, exp_ov);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cs_n"}, cs_n, 1);
    check({tag, "_sclk"}, sclk, 0);
    check({tag, "_mosi"}, mosi, 0);
    check({tag, "_tx_ready"}, tx_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_cnt"}, frame_cnt, 0);
    check({tag, "_overrun"}, overrun, 0);
  endtask

  // Source: presents the queue head, pops it when the handshake completes.
  logic drv_hs;
  initial begin
    forever begin
      @(negedge clk_27);
      drv_hs = tx_valid && tx_ready && !rst;
      @(posedge clk_27);
      #1;
      if (drv_hs && src.size() > 0) void'(src.pop_front());
      tx_valid = (src.size() > 0);
      if (src.size() > 0) tx_data = src[0];
      else tx_data = 8'h00;
    end
  end

  // Monitor: captures mosi on sclk rises while cs_n is low, scores each frame at cs_n rise.
  logic mon_prev_cs = 1'b1, mon_prev_sclk = 1'b0, mon_prev_mosi = 1'b0;
  logic mon_bits[$];
  int   mon_cs_len = 0, mon_hi = 0, mon_rdy = 0, mon_idle_bad = 0, mon_edge_bad = 0;

  task automatic score_frame();
    int         n, r;
    logic [7:0] eb, ab;
    if (exp_len.size() == 0) begin
      total++; bad++;
      $display("FAIL unexpected_frame: got %0d bits, expected no frame", mon_bits.size());
    end else begin
      n = exp_len.pop_front();
      r = exp_rdy.pop_front();
      check("frame_bits", mon_bits.size(), n * 8);
      check("cs_low_cycles", mon_cs_len, n * 8 * CLK_DIV);
      check("sclk_high_cycles", mon_hi, n * 8 * (CLK_DIV / 2));
      check("ready_pulses", mon_rdy, r);
      for (int i = 0; i < n; i++) begin
        eb = exp_bytes.pop_front();
        ab = 8'h00;
        for (int j = 0; j < 8; j++)
          ab = {ab[6:0], (i * 8 + j < mon_bits.size()) ? mon_bits[i * 8 + j] : 1'b0};
        check($sformatf("byte%0d", i), ab, eb);
      end
    end
    mon_bits.delete();
    mon_cs_len = 0; mon_hi = 0; mon_rdy = 0;
  endtask

  always @(negedge clk_27) begin
    if (rst) begin
      mon_bits.delete();
      mon_cs_len = 0; mon_hi = 0; mon_rdy = 0;
      mon_prev_cs = 1'b1; mon_prev_sclk = 1'b0; mon_prev_mosi = 1'b0;
    end else begin
      if (tx_ready) mon_rdy++;
      if (!cs_n) begin
        mon_cs_len++;
        if (sclk) mon_hi++;
        if (sclk && !mon_prev_sclk) mon_bits.push_back(mosi);
        if (!mon_prev_cs && mosi != mon_prev_mosi && !(mon_prev_sclk && !sclk)) mon_edge_bad++;
      end else if (sclk || mosi) begin
        mon_idle_bad++;
      end
      if (cs_n && !mon_prev_cs) score_frame();
      mon_prev_cs = cs_n; mon_prev_sclk = sclk; mon_prev_mosi = mosi;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk_27);
    #1 check_reset("por");
    rst = 1'b0;
    repeat (3) @(posedge clk_27);

    // Header-only, two-byte payload, oversize payload.
    pl.delete(); run_frame(pl);
    pl = '{8'hA5, 8'h3C}; run_frame(pl);
    pl = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60}; run_frame(pl);

    // Random payload lengths around MAX_BYTES.
    for (int f = 0; f < 20; f++) begin
      pl.delete();
      for (int i = 0; i < int'($urandom_range(0, 6)); i++) pl.push_back(8'($urandom));
      run_frame(pl);
    end

    // vsync rise mid-frame: flagged, not framed.
    pl = '{8'h11, 8'h22};
    push_frame(pl);
    pulse_vsync();
    mcnt = (mcnt + 1) % 256;
    repeat (3 * CLK_DIV) @(posedge clk_27);
    pulse_vsync();
    @(negedge clk_27);
    check("overrun_set", overrun, 1);
    check("frame_cnt_hold", frame_cnt, mcnt);
    exp_ov = 1'b1;
    wait_busy(1'b0);
    src.delete();
    check("overrun_sticky", overrun, 1);
    check("frame_cnt_after_overrun", frame_cnt, mcnt);

    // Reset in the middle of the second byte of a frame.
    src = '{8'h5A, 8'hC3, 8'h0F};
    pulse_vsync();
    repeat (11 * CLK_DIV + 3) @(posedge clk_27);
    #3 rst = 1'b1;
    #1 check_reset("mid_reset");
    src.delete();
    repeat (2) @(posedge clk_27);
    #1 rst = 1'b0;
    mcnt = 0; exp_ov = 1'b0;
    exp_len.delete(); exp_bytes.delete(); exp_rdy.delete();
    pl.delete(); run_frame(pl);

    // Rise exactly on the last GAP cycle counts as a busy rise.
    pl.delete();
    push_frame(pl);
    pulse_vsync();
    mcnt = (mcnt + 1) % 256;
    wait_cs(1'b0);
    wait_cs(1'b1);
    repeat (CLK_DIV - 1) @(posedge clk_27);
    #1 vsync = 1'b1;
    @(negedge clk_27);
    check("gap_last_busy", busy, 1);
    @(negedge clk_27);
    check("gap_end_idle", busy, 0);
    check("gap_edge_overrun", overrun, 1);
    repeat (4 * CLK_DIV) @(negedge clk_27);
    check("gap_edge_no_frame", busy, 0);
    check("gap_edge_frame_cnt", frame_cnt, mcnt);
    vsync = 1'b0;

    // Fresh reset: header 0x00 with payload 0x01, then wrap the frame counter.
    @(posedge clk_27); #1 rst = 1'b1;
    repeat (2) @(posedge clk_27);
    #1 rst = 1'b0;
    mcnt = 0; exp_ov = 1'b0;
    pl = '{8'h01}; run_frame(pl);
    pl.delete();
    for (int f = 0; f < 255; f++) run_frame(pl);
    check("frame_cnt_wrap", frame_cnt, 0);

    repeat (4) @(negedge clk_27);
    check("pending_frames", exp_len.size(), 0);
    check("idle_lines", mon_idle_bad, 0);
    check("mosi_edges", mon_edge_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
